vx_ipdom_ctrl: RTL
==================

# vx_ipdom_ctrl

Split/join sequencer for the per-warp IPDOM stacks in the SIMT core. Accepts split and join requests from the GPU unit and arbitrates between them, one operation per cycle. Drives push/pop/pair/data onto the selected warp's IPDOM stack and returns the resulting thread mask and PC update to the warp scheduler one cycle later. Also keeps divergence performance counters and a sticky misuse error.

## Interface
- NUM_WARPS, 4, warps; one IPDOM stack each
- NUM_THREADS, 4, thread-mask width
- PC_WIDTH, 32, PC width
- EW, NUM_THREADS+PC_WIDTH (derived), stack entry width; entry = {mask, pc}
- WB, max(1,$clog2(NUM_WARPS)) (derived), warp-id width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- split_valid / split_ready  in/out  1  split request handshake
- split_wid  in  WB  target warp
- split_tmask  in  NUM_THREADS  current active mask
- split_cond  in  NUM_THREADS  per-thread branch predicate
- split_else_pc  in  PC_WIDTH  PC of the not-taken path
- join_valid / join_ready  in/out  1  join request handshake
- join_wid  in  WB  target warp
- stk_push, stk_pop  out  NUM_WARPS  one-hot per-warp stack strobes
- stk_pair  out  1  1 = divergent pair push
- stk_q1, stk_q2  out  EW  push data (shared by all stacks)
- stk_d  in  NUM_WARPS*EW  per-warp top-of-stack data (combinational)
- stk_index, stk_empty, stk_full  in  NUM_WARPS  per-warp stack status
- wctl_valid  out  1  mask/PC update pulse
- wctl_wid  out  WB; wctl_tmask  out  NUM_THREADS; wctl_pc  out  PC_WIDTH; wctl_setpc  out  1
- perf_splits, perf_diverge  out  32  wrapping counters
- err  out  2  sticky: bit0 join on empty stack, bit1 reserved (0)

## Operation
- Eligibility: split needs split_valid & !stk_full[split_wid]; join needs join_valid.
- split_ready = split granted; join_ready = join granted. A request fires on valid & ready in the same cycle.
- Arbitration when both are eligible: round-robin priority bit `prio` (0 = split first). It toggles only on a contended grant. Uncontended grants leave it unchanged.
- Split: taken = tmask & cond, ntaken = tmask & ~cond, divergent = (taken != 0) & (ntaken != 0).
  - Divergent: stk_push[wid]=1, stk_pair=1, q1={tmask,0}, q2={ntaken,else_pc}. Result tmask=taken, setpc=0.
  - Uniform: stk_push[wid]=1, stk_pair=0, q1={tmask,0}, q2=0. Result tmask=tmask, setpc=0.
  - perf_splits+1; perf_diverge+1 if divergent.
- Join on non-empty stack: sample e=stk_d[wid], ix=stk_index[wid] in the grant cycle, then assert stk_pop[wid].
  - ix=0 (else path pending): result tmask=e.mask, pc=e.pc, setpc=1.
  - ix=1 (reconverge): result tmask=e.mask, setpc=0, pc=0.
- Join on empty stack: consumed, no pop, no wctl pulse, err[0] set (sticky until reset).
- At most one stk_push/stk_pop bit is high per cycle. Push and pop are never both high.
- Outputs are 0 whenever idle: stk_* strobes, stk_pair, stk_q1, stk_q2.

## Timing
- Request handshake and stack strobes are combinational in grant cycle N. Stacks update at edge N.
- wctl_* are registered: valid at N+1 for exactly one cycle. wctl_tmask/pc/setpc/wid are held at 0 when wctl_valid=0.
- Back-to-back ops on the same warp are legal every cycle. The N+1 request sees the stack already updated at edge N.
- split stalls (ready=0) while stk_full[split_wid]. A stalled split does not block an eligible join.
- Counters wrap 0xFFFFFFFF→0.
- Reset (async assert, sync deassert): wctl_valid=0, all wctl_* 0, prio=0, perf_* 0, err 0, ready low during reset. Reset mid-operation drops any in-flight wctl result. Stacks are reset by the same reset.

## Test plan
- Divergent split w1: tmask=1111, cond=0011, else_pc=0x200 → push[1], pair=1, q2={1100,0x200}. Next cycle wctl tmask=0011, setpc=0, perf_diverge=1.
- Follow with two joins w1 (stack model) → first: tmask=1100, pc=0x200, setpc=1. Second: tmask=1111, setpc=0. Stack empty afterwards.
- Uniform split cond=1111 then join → pair=0. Both results tmask=1111, setpc=0, perf_diverge unchanged.
- Split w0 and join w2 valid every cycle for 4 cycles → grants alternate S,J,S,J. Never both ready in one cycle.
- stk_full[3]=1 with split w3 and join w0 pending → split_ready=0, join granted. Split granted the cycle after full drops.
- Join w2 on empty → join_ready=1, no pop, no wctl. err=01 persists until reset is asserted mid-stream, then everything reads 0.

Source files
------------

// File: rtl/vx_ipdom_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vx_ipdom_ctrl
// Purpose  : Split/join sequencer for the per-warp IPDOM stacks of a SIMT
//            core. Arbitrates between split and join requests (one operation
//            per cycle, round-robin on contention). Drives push/pop/pair/data
//            strobes onto the selected warp's stack, and returns the
//            resulting thread mask / PC update to the warp scheduler one
//            cycle later. Also keeps divergence counters and a sticky
//            misuse error.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, reset_ni            clock, asynchronous active-low reset
//   split_valid_i/ready_o      split request handshake
//   split_wid_i                target warp of the split
//   split_tmask_i, split_cond_i current active mask, per-thread predicate
//   split_else_pc_i            PC of the not-taken path
//   join_valid_i/ready_o       join request handshake
//   join_wid_i                 target warp of the join
//   stk_push_o, stk_pop_o      one-hot per-warp stack strobes
//   stk_pair_o                 1 = divergent pair push
//   stk_q1_o, stk_q2_o         push data, entry = {mask, pc}
//   stk_d_i                    per-warp top-of-stack entry (combinational)
//   stk_index_i/empty_i/full_i per-warp stack status
//   wctl_*_o                   registered mask/PC update, one-cycle pulse
//   perf_splits_o/diverge_o    wrapping 32-bit event counters
//   err_o                      sticky: bit0 join on empty stack, bit1 zero
// ============================================================================
module vx_ipdom_ctrl #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 32,
  localparam int EW         = NUM_THREADS + PC_WIDTH,
  localparam int WB         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,

  input  logic                      split_valid_i,
  output logic                      split_ready_o,
  input  logic [WB-1:0]             split_wid_i,
  input  logic [NUM_THREADS-1:0]    split_tmask_i,
  input  logic [NUM_THREADS-1:0]    split_cond_i,
  input  logic [PC_WIDTH-1:0]       split_else_pc_i,

  input  logic                      join_valid_i,
  output logic                      join_ready_o,
  input  logic [WB-1:0]             join_wid_i,

  output logic [NUM_WARPS-1:0]      stk_push_o,
  output logic [NUM_WARPS-1:0]      stk_pop_o,
  output logic                      stk_pair_o,
  output logic [EW-1:0]             stk_q1_o,
  output logic [EW-1:0]             stk_q2_o,
  input  logic [NUM_WARPS*EW-1:0]   stk_d_i,
  input  logic [NUM_WARPS-1:0]      stk_index_i,
  input  logic [NUM_WARPS-1:0]      stk_empty_i,
  input  logic [NUM_WARPS-1:0]      stk_full_i,

  output logic                      wctl_valid_o,
  output logic [WB-1:0]             wctl_wid_o,
  output logic [NUM_THREADS-1:0]    wctl_tmask_o,
  output logic [PC_WIDTH-1:0]       wctl_pc_o,
  output logic                      wctl_setpc_o,

  output logic [31:0]               perf_splits_o,
  output logic [31:0]               perf_diverge_o,
  output logic [1:0]                err_o
);

  localparam logic [NUM_WARPS-1:0] ONE_HOT_LSB = {{(NUM_WARPS-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Unpack the flat top-of-stack bus into one entry per warp
  // --------------------------------------------------------------------------
  logic [EW-1:0] w_stk_d [NUM_WARPS];

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_unpack
    assign w_stk_d[gi] = stk_d_i[gi*EW +: EW];
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic                   prio_q,         prio_d;
  logic                   wctl_valid_q,   wctl_valid_d;
  logic [WB-1:0]          wctl_wid_q,     wctl_wid_d;
  logic [NUM_THREADS-1:0] wctl_tmask_q,   wctl_tmask_d;
  logic [PC_WIDTH-1:0]    wctl_pc_q,      wctl_pc_d;
  logic                   wctl_setpc_q,   wctl_setpc_d;
  logic [31:0]            perf_splits_q,  perf_splits_d;
  logic [31:0]            perf_diverge_q, perf_diverge_d;
  logic                   err_empty_q,    err_empty_d;

  // --------------------------------------------------------------------------
  // Eligibility and arbitration
  // --------------------------------------------------------------------------
  logic w_split_elig;
  logic w_join_elig;
  logic w_contend;
  logic w_grant_split;
  logic w_grant_join;

  // Readies are forced low while reset is held, independent of the inputs.
  assign w_split_elig  = reset_ni & split_valid_i & ~stk_full_i[split_wid_i];
  assign w_join_elig   = reset_ni & join_valid_i;
  assign w_contend     = w_split_elig & w_join_elig;

  // prio_q = 0 gives split the win on contention, 1 gives join the win.
  assign w_grant_split = w_split_elig & (~w_join_elig | ~prio_q);
  assign w_grant_join  = w_join_elig  & (~w_split_elig |  prio_q);

  assign split_ready_o = w_grant_split;
  assign join_ready_o  = w_grant_join;

  // --------------------------------------------------------------------------
  // Split decode
  // --------------------------------------------------------------------------
  logic [NUM_THREADS-1:0] w_taken;
  logic [NUM_THREADS-1:0] w_ntaken;
  logic                   w_divergent;

  assign w_taken     = split_tmask_i & split_cond_i;
  assign w_ntaken    = split_tmask_i & ~split_cond_i;
  assign w_divergent = (|w_taken) & (|w_ntaken);

  // --------------------------------------------------------------------------
  // Join decode: the top entry and index are sampled in the grant cycle,
  // before the pop takes effect at the clock edge.
  // --------------------------------------------------------------------------
  logic          w_join_empty;
  logic          w_join_pop;
  logic [EW-1:0] w_join_entry;
  logic          w_join_ix;

  assign w_join_empty = stk_empty_i[join_wid_i];
  assign w_join_pop   = w_grant_join & ~w_join_empty;
  assign w_join_entry = w_stk_d[join_wid_i];
  assign w_join_ix    = stk_index_i[join_wid_i];

  // --------------------------------------------------------------------------
  // Stack strobes and push data (all zero when no stack operation)
  // --------------------------------------------------------------------------
  always_comb begin
    stk_push_o = '0;
    stk_pop_o  = '0;
    stk_pair_o = 1'b0;
    stk_q1_o   = '0;
    stk_q2_o   = '0;
    if (w_grant_split) begin
      stk_push_o = ONE_HOT_LSB << split_wid_i;
      // q1 holds the reconvergence mask; its PC is never used on pop.
      stk_q1_o   = {split_tmask_i, {PC_WIDTH{1'b0}}};
      if (w_divergent) begin
        stk_pair_o = 1'b1;
        stk_q2_o   = {w_ntaken, split_else_pc_i};
      end
    end else if (w_join_pop) begin
      stk_pop_o = ONE_HOT_LSB << join_wid_i;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    prio_d         = prio_q;
    wctl_valid_d   = 1'b0;
    wctl_wid_d     = '0;
    wctl_tmask_d   = '0;
    wctl_pc_d      = '0;
    wctl_setpc_d   = 1'b0;
    perf_splits_d  = perf_splits_q;
    perf_diverge_d = perf_diverge_q;
    err_empty_d    = err_empty_q;

    // Only a contended grant rotates priority.
    if (w_contend) begin
      prio_d = ~prio_q;
    end

    if (w_grant_split) begin
      wctl_valid_d  = 1'b1;
      wctl_wid_d    = split_wid_i;
      wctl_tmask_d  = w_divergent ? w_taken : split_tmask_i;
      perf_splits_d = perf_splits_q + 32'd1;
      if (w_divergent) begin
        perf_diverge_d = perf_diverge_q + 32'd1;
      end
    end else if (w_join_pop) begin
      wctl_valid_d = 1'b1;
      wctl_wid_d   = join_wid_i;
      wctl_tmask_d = w_join_entry[EW-1 -: NUM_THREADS];
      // Index 0: else path still pending, jump to it.
      // Index 1: reconverge, mask restore only.
      if (!w_join_ix) begin
        wctl_pc_d    = w_join_entry[PC_WIDTH-1:0];
        wctl_setpc_d = 1'b1;
      end
    end

    // A join on an empty stack is consumed silently apart from this flag.
    if (w_grant_join && w_join_empty) begin
      err_empty_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      prio_q         <= 1'b0;
      wctl_valid_q   <= 1'b0;
      wctl_wid_q     <= '0;
      wctl_tmask_q   <= '0;
      wctl_pc_q      <= '0;
      wctl_setpc_q   <= 1'b0;
      perf_splits_q  <= '0;
      perf_diverge_q <= '0;
      err_empty_q    <= 1'b0;
    end else begin
      prio_q         <= prio_d;
      wctl_valid_q   <= wctl_valid_d;
      wctl_wid_q     <= wctl_wid_d;
      wctl_tmask_q   <= wctl_tmask_d;
      wctl_pc_q      <= wctl_pc_d;
      wctl_setpc_q   <= wctl_setpc_d;
      perf_splits_q  <= perf_splits_d;
      perf_diverge_q <= perf_diverge_d;
      err_empty_q    <= err_empty_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign wctl_valid_o   = wctl_valid_q;
  assign wctl_wid_o     = wctl_wid_q;
  assign wctl_tmask_o   = wctl_tmask_q;
  assign wctl_pc_o      = wctl_pc_q;
  assign wctl_setpc_o   = wctl_setpc_q;
  assign perf_splits_o  = perf_splits_q;
  assign perf_diverge_o = perf_diverge_q;
  assign err_o          = {1'b0, err_empty_q};

endmodule
`default_nettype wire
